// File: rtl/dmem_if.sv
// Request/response bus between a load/store initiator and the data-memory
// responder. The initiator drives the master modport; the memory the slave.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_ctrl,
        output req_addr,
        output req_wdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_ctrl,
        input  req_addr,
        input  req_wdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte/half/word loads and stores, a fixed
// number of wait states per access and a registered, held response.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_WAIT | request latched, wait-state down-counter running
// ST_RESP | access done, rsp_rdata/rsp_err held until rsp_ready
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Operation currently being executed; normally the latched request, but
    // with zero wait states the access happens on the accept edge itself.
    logic [3:0]  op_ctrl;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        enter_resp;

    logic        op_legal;
    logic        op_store;
    logic        op_unsigned;
    size_t       op_size;
    logic        op_misaligned;
    logic        op_oob;
    logic        op_err;

    logic [31:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0] mem_idx;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [4:0]  lane_sh;
    logic [31:0] load_data;
    logic [31:0] rsp_data;
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic        mem_we;

    // State and request registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ctrl_q  <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_ctrl    = ctrl_q;
        op_addr    = addr_q;
        op_wdata   = wdata_q;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ctrl_d  = bus.req_ctrl;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        op_ctrl    = bus.req_ctrl;
                        op_addr    = bus.req_addr;
                        op_wdata   = bus.req_wdata;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                // Terminal count: the edge that would bring the counter to 0.
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Access-type decode and error classification.
    always_comb begin
        op_legal    = 1'b1;
        op_store    = 1'b0;
        op_unsigned = 1'b0;
        op_size     = SZ_WORD;
        case (op_ctrl)
            4'b0001: op_size = SZ_BYTE;
            4'b0010: op_size = SZ_HALF;
            4'b0011: op_size = SZ_WORD;
            4'b0100: begin op_size = SZ_BYTE; op_unsigned = 1'b1; end
            4'b0101: begin op_size = SZ_HALF; op_unsigned = 1'b1; end
            4'b1001: begin op_size = SZ_BYTE; op_store = 1'b1; end
            4'b1010: begin op_size = SZ_HALF; op_store = 1'b1; end
            4'b1011: begin op_size = SZ_WORD; op_store = 1'b1; end
            default: op_legal = 1'b0;
        endcase

        op_misaligned = ((op_size == SZ_HALF) && op_addr[0]) ||
                        ((op_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
        // Compare the full word index so high address bits never alias.
        op_oob = ({2'b00, op_addr[31:2]} >= DEPTH_WORDS);
        op_err = !op_legal || op_misaligned || op_oob;
    end

    // Load extraction and store lane steering.
    always_comb begin
        mem_idx  = op_addr[IDX_W+1:2];
        rd_word  = mem[mem_idx];
        lane_sh  = {op_addr[1:0], 3'b000};
        rd_shift = rd_word >> lane_sh;

        case (op_size)
            SZ_BYTE: load_data = op_unsigned ? {24'd0, rd_shift[7:0]}
                                             : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_data = op_unsigned ? {16'd0, rd_shift[15:0]}
                                             : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase

        case (op_size)
            SZ_BYTE: wr_be = 4'b0001 << op_addr[1:0];
            SZ_HALF: wr_be = 4'b0011 << op_addr[1:0];
            default: wr_be = 4'b1111;
        endcase
        wr_lanes = op_wdata << lane_sh;

        rsp_data = (op_err || op_store) ? 32'd0 : load_data;
        // A store is committed only on a non-reset edge entering RESP, so a
        // reset during WAIT abandons it without touching memory.
        mem_we   = enter_resp && rst_n && op_store && !op_err;
    end

    // Response capture happens only on the edge entering RESP.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            rdata_d = rsp_data;
            err_d   = op_err;
        end
    end

    // Storage array: no reset, byte-lane writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Bus outputs.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

    localparam logic [3:0] C_LB  = 4'b0001;
    localparam logic [3:0] C_LH  = 4'b0010;
    localparam logic [3:0] C_LW  = 4'b0011;
    localparam logic [3:0] C_LBU = 4'b0100;
    localparam logic [3:0] C_LHU = 4'b0101;
    localparam logic [3:0] C_SB  = 4'b1001;
    localparam logic [3:0] C_SH  = 4'b1010;
    localparam logic [3:0] C_SW  = 4'b1011;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let it be accepted, then drive junk while busy.
    task automatic accept(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] w);
        int t;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check_vec({tag, "/ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_ctrl  = c;
        bus.req_addr  = a;
        bus.req_wdata = w;
        tick();
        bus.req_ctrl  = C_SW;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'hA5A5_5A5A;
    endtask

    task automatic wait_rsp(input string tag);
        int lat;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        bus.req_valid = 1'b0;
        check_vec({tag, "/lat"}, 32'(lat), 32'd2);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] exp_d, input logic exp_e);
        accept(tag, c, a, w);
        wait_rsp(tag);
        check_vec({tag, "/rdata"}, bus.rsp_rdata, exp_d);
        check_vec({tag, "/err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
        finish_rsp();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_ctrl  = 4'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        tick();
        check_vec("rst/req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_vec("rst/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_vec("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
        check_vec("rst/rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic word, byte and half accesses on word 0x10.
        txn("sw10",   C_SW,  32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0);
        txn("lw10",   C_LW,  32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        txn("sb11",   C_SB,  32'h11, 32'h0000_0080, 32'h0,         1'b0);
        txn("lb11",   C_LB,  32'h11, 32'h0,         32'hFFFF_FF80, 1'b0);
        txn("lbu11",  C_LBU, 32'h11, 32'h0,         32'h0000_0080, 1'b0);
        txn("lw10b",  C_LW,  32'h10, 32'h0,         32'hDEAD_80EF, 1'b0);
        txn("sh12",   C_SH,  32'h12, 32'hFFFF_1234, 32'h0,         1'b0);
        txn("lw10c",  C_LW,  32'h10, 32'h0,         32'h1234_80EF, 1'b0);
        txn("lh12",   C_LH,  32'h12, 32'h0,         32'h0000_1234, 1'b0);
        txn("sh10",   C_SH,  32'h10, 32'h0000_A5C3, 32'h0,         1'b0);
        txn("lh10",   C_LH,  32'h10, 32'h0,         32'hFFFF_A5C3, 1'b0);
        txn("lhu10",  C_LHU, 32'h10, 32'h0,         32'h0000_A5C3, 1'b0);
        txn("lb13",   C_LB,  32'h13, 32'h0,         32'h0000_0012, 1'b0);
        txn("lb10",   C_LB,  32'h10, 32'h0,         32'hFFFF_FFC3, 1'b0);
        txn("lbu10",  C_LBU, 32'h10, 32'h0,         32'h0000_00C3, 1'b0);

        // Alignment and decode errors.
        txn("lh13",   C_LH,  32'h13, 32'h0,         32'h0,         1'b1);
        txn("sw12",   C_SW,  32'h12, 32'hFFFF_FFFF, 32'h0,         1'b1);
        txn("lw10d",  C_LW,  32'h10, 32'h0,         32'h1234_A5C3, 1'b0);
        txn("c0111",  4'b0111, 32'h10, 32'h0,       32'h0,         1'b1);
        txn("c0000",  4'b0000, 32'h10, 32'h0,       32'h0,         1'b1);
        txn("c1111",  4'b1111, 32'h10, 32'h0,       32'h0,         1'b1);

        // Depth boundary: last word valid, one past the end errors and does not alias.
        txn("sw0",    C_SW,  32'h0,    32'h1122_3344, 32'h0,         1'b0);
        txn("swlast", C_SW,  32'hFFC,  32'h55AA_55AA, 32'h0,         1'b0);
        txn("lwlast", C_LW,  32'hFFC,  32'h0,         32'h55AA_55AA, 1'b0);
        txn("lwoob",  C_LW,  32'h1000, 32'h0,         32'h0,         1'b1);
        txn("swoob",  C_SW,  32'h1000, 32'hCAFE_F00D, 32'h0,         1'b1);
        txn("lw0",    C_LW,  32'h0,    32'h0,         32'h1122_3344, 1'b0);

        // Response back-pressure.
        accept("bp", C_LW, 32'h10, 32'h0);
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            check_vec("bp/rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check_vec("bp/rsp_rdata", bus.rsp_rdata, 32'h1234_A5C3);
            check_vec("bp/req_ready", {31'd0, bus.req_ready}, 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_vec("bp/rel_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_vec("bp/rel_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset during WAIT, on the edge that would otherwise commit the store.
        txn("sw20",   C_SW, 32'h20, 32'h600D_CAFE, 32'h0, 1'b0);
        accept("rw", C_SW, 32'h20, 32'h0BAD_F00D);
        tick();
        rst_n = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        check_vec("rw/req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_vec("rw/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        txn("lw20",   C_LW, 32'h20, 32'h0, 32'h600D_CAFE, 1'b0);

        // Reset during RESP: response dropped, completed store kept.
        accept("rr", C_SW, 32'h24, 32'h1357_9BDF);
        wait_rsp("rr");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_vec("rr/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_vec("rr/req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_vec("rr/rsp_rdata", bus.rsp_rdata, 32'd0);
        check_vec("rr/rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        txn("lw24",   C_LW, 32'h24, 32'h0, 32'h1357_9BDF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal storage array; word index is req_addr[31:2].
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response (range 0..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_ctrl  input  4  access type per REQ-012.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_rdata / rsp_err  output / output  32 / 1  load result, right-aligned and extended; error flag.

Function
REQ-012 req_ctrl decode SHALL be: 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; all other codes, including 0000, are invalid.
REQ-013 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-014 A request is accepted at a rising edge where req_valid && req_ready; ctrl, addr and wdata SHALL be latched at that edge.
- Edge k: IDLE->WAIT with counter loaded to WAIT_CYCLES; if WAIT_CYCLES=0, IDLE->RESP.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where it would reach 0; total edges from accept to RESP entry = max(WAIT_CYCLES,1) when WAIT_CYCLES>0, and 1 when WAIT_CYCLES=0.
REQ-016 Memory read/write and rdata/err capture SHALL occur on the edge entering RESP; rsp_rdata/rsp_err SHALL be stable throughout RESP.
REQ-017 RESP SHALL hold until rsp_valid && rsp_ready, then go to IDLE; there is at least one IDLE cycle between a response and the next accept.
REQ-018 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected byte/half from word[addr[1:0]*8 +: n], little-endian; LW returns the whole word.
REQ-019 Stores SHALL update only the addressed byte lanes; other lanes are unchanged; rsp_rdata=0 for stores.
REQ-020 Error (rsp_err=1, rsp_rdata=0, no memory write) SHALL be raised for: invalid ctrl; half access with addr[0]=1; word access with addr[1:0]!=0; or addr[31:2]>=DEPTH_WORDS.
REQ-021 Input changes on req_* while not in IDLE SHALL be ignored.
REQ-022 Storage contents SHALL NOT be initialised by reset; reads of never-written words return X in simulation.

Reset
REQ-023 While rst_n=0 at a rising edge, the state SHALL become IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0 after that edge.
REQ-024 Reset asserted in WAIT SHALL abandon the request; a store not yet committed SHALL NOT write memory.
REQ-025 Reset asserted in RESP SHALL drop rsp_valid with no handshake; the completed store remains in memory.

Verification
REQ-026 WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF accepted at edge k -> rsp_valid=1 after edge k+2, rsp_err=0; then LW 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-027 After REQ-026: SB 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-028 LH 0x13 -> rsp_err=1, rsp_rdata=0; SW 0x12 -> rsp_err=1 and LW 0x10 is unchanged; ctrl=0111 -> rsp_err=1.
REQ-029 LW at addr 4*DEPTH_WORDS -> rsp_err=1; SW at the same address causes no aliasing write to word 0.
REQ-030 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay constant and req_ready stays 0; raising rsp_ready -> IDLE on the next edge.
REQ-031 SW 0x20 with rst_n pulled low during WAIT -> after reset req_ready=1, rsp_valid=0; LW 0x20 returns the previous contents, not the new store data.
